// File: rtl/fpu_pkg.sv
// Shared FPU definitions for the binary32 multiplier datapath.
//   fp32_t      : packed IEEE-754 binary32 view (sign / exp[7:0] / man[22:0])
//   fp_class_t  : operand / product classification
//   classify()  : classify one operand (denormals classify as ZERO)
//   mul_class() : combine two operand classes into the product class
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7fc0_0000;

    // Signed 10-bit forms used by the exponent datapath.
    localparam logic signed [9:0] EXP_BIAS_S = 10'sd127;
    localparam logic signed [9:0] EXP_MAX_S  = 10'sd255;

    function automatic fp_class_t classify(input fp32_t f);
        fp_class_t c;
        if (f.exp == 8'd0) begin
            c = ZERO;                       // denormals flush to zero
        end else if (f.exp == 8'(EXP_MAX)) begin
            c = (f.man != '0) ? NAN : INF;
        end else begin
            c = NORM;
        end
        return c;
    endfunction

    // Priority: NaN (incl. inf*0) > inf > zero > normal.
    function automatic fp_class_t mul_class(input fp_class_t c1, input fp_class_t c2);
        fp_class_t c;
        if ((c1 == NAN) || (c2 == NAN) ||
            ((c1 == INF) && (c2 == ZERO)) || ((c1 == ZERO) && (c2 == INF))) begin
            c = NAN;
        end else if ((c1 == INF) || (c2 == INF)) begin
            c = INF;
        end else if ((c1 == ZERO) || (c2 == ZERO)) begin
            c = ZERO;
        end else begin
            c = NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fmul_round.sv
// Combinational normalise + round-to-nearest-even + pack for the binary32
// multiplier.
//   prod_i : 48-bit product of the two 24-bit significands (1.xx * 1.xx)
//   sign_i : result sign
//   exp_i  : biased exponent e1+e2-127, 10-bit signed, before normalisation
//   cls_i  : product class (special cases override the arithmetic result)
//   y_o    : packed binary32 result
//   ovf_o  : finite*finite overflowed to +/-inf
//   unf_o  : nonzero finite product flushed to +/-0
module fmul_round
    import fpu_pkg::*;
(
    input  logic [47:0]        prod_i,
    input  logic               sign_i,
    input  logic signed [9:0]  exp_i,
    input  fp_class_t          cls_i,
    output logic [31:0]        y_o,
    output logic               ovf_o,
    output logic               unf_o
);

    logic [22:0]       mant;
    logic              guard;
    logic              sticky;
    logic              rnd_up;
    logic [23:0]       mant_r;
    logic signed [9:0] e_norm;
    logic signed [9:0] e_fin;

    always_comb begin
        // Product lies in [1,4): a set bit 47 means one extra exponent step.
        if (prod_i[47]) begin
            mant   = prod_i[46:24];
            guard  = prod_i[23];
            sticky = |prod_i[22:0];
            e_norm = exp_i + 10'sd1;
        end else begin
            mant   = prod_i[45:23];
            guard  = prod_i[22];
            sticky = |prod_i[21:0];
            e_norm = exp_i;
        end

        rnd_up = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {23'd0, rnd_up};
        // Carry out of the fraction means 1.111..1 rounded to 10.000..0;
        // the fraction bits are already zero, only the exponent moves.
        e_fin  = mant_r[23] ? (e_norm + 10'sd1) : e_norm;

        y_o   = '0;
        ovf_o = 1'b0;
        unf_o = 1'b0;
        case (cls_i)
            NAN:  y_o = QNAN;
            INF:  y_o = {sign_i, 8'hff, 23'd0};
            ZERO: y_o = {sign_i, 31'd0};
            default: begin
                if (e_fin >= EXP_MAX_S) begin
                    y_o   = {sign_i, 8'hff, 23'd0};
                    ovf_o = 1'b1;
                end else if (e_fin <= 10'sd0) begin
                    y_o   = {sign_i, 31'd0};
                    unf_o = 1'b1;
                end else begin
                    y_o = {sign_i, e_fin[7:0], mant_r[22:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 binary32 multiplier, y = x1*x2 with RNE rounding.
// Each stage is a valid bit plus a payload; a stage loads whenever it is
// empty or its content moves on, so bubbles collapse and a full pipeline
// holds NSTAGE operations.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (x1, x2, in_tag)
//   out_valid/out_ready : result handshake (y, ovf, unf, out_tag)
// Stage 1 unpacks/classifies, stage 2 multiplies significands, stage 3
// normalises/rounds/packs; NSTAGE=2 merges the last two, NSTAGE>3 appends
// plain retiming stages.
module fmul_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic             ovf,
    output logic             unf,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic              sign;
        logic signed [9:0] exp;
        fp_class_t         cls;
        logic [23:0]       m1;
        logic [23:0]       m2;
        logic [TAG_W-1:0]  tag;
    } p1_t;

    typedef struct packed {
        logic              sign;
        logic signed [9:0] exp;
        fp_class_t         cls;
        logic [47:0]       prod;
        logic [TAG_W-1:0]  tag;
    } p2_t;

    typedef struct packed {
        logic [31:0]      y;
        logic             ovf;
        logic             unf;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic [NSTAGE:1] vld_q;
    logic [NSTAGE:1] ld;
    logic            chain;

    // ld[i]: stage i takes the content of stage i-1 this cycle.
    always_comb begin
        chain = out_ready;
        ld    = '0;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            chain          = !vld_q[NSTAGE - i] || chain;
            ld[NSTAGE - i] = chain;
        end
    end

    assign in_ready  = ld[1];
    assign out_valid = vld_q[NSTAGE];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            if (ld[1]) begin
                vld_q[1] <= in_valid;
            end
            for (int unsigned i = 2; i <= NSTAGE; i++) begin
                if (ld[i]) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end
    end

    // ---------------- stage 1: unpack + classify ----------------
    fp32_t a;
    fp32_t b;
    p1_t   p1_d;
    p1_t   p1_q;

    assign a = fp32_t'(x1);
    assign b = fp32_t'(x2);

    always_comb begin
        p1_d.sign = a.sign ^ b.sign;
        p1_d.exp  = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - EXP_BIAS_S;
        p1_d.cls  = mul_class(classify(a), classify(b));
        p1_d.m1   = {1'b1, a.man};
        p1_d.m2   = {1'b1, b.man};
        p1_d.tag  = in_tag;
    end

    always_ff @(posedge clk) begin
        if (ld[1]) begin
            p1_q <= p1_d;
        end
    end

    // ---------------- rounding unit (shared by both layouts) ----------------
    logic [47:0]       rnd_prod;
    logic              rnd_sign;
    logic signed [9:0] rnd_exp;
    fp_class_t         rnd_cls;
    logic [TAG_W-1:0]  rnd_tag;
    res_t              rnd_res;
    res_t              res_out;

    fmul_round u_round (
        .prod_i (rnd_prod),
        .sign_i (rnd_sign),
        .exp_i  (rnd_exp),
        .cls_i  (rnd_cls),
        .y_o    (rnd_res.y),
        .ovf_o  (rnd_res.ovf),
        .unf_o  (rnd_res.unf)
    );
    assign rnd_res.tag = rnd_tag;

    generate
        if (NSTAGE == 2) begin : g_merge
            res_t res2_q;

            assign rnd_prod = 48'(p1_q.m1) * 48'(p1_q.m2);
            assign rnd_sign = p1_q.sign;
            assign rnd_exp  = p1_q.exp;
            assign rnd_cls  = p1_q.cls;
            assign rnd_tag  = p1_q.tag;

            always_ff @(posedge clk) begin
                if (rst) begin
                    res2_q <= '0;
                end else if (ld[2]) begin
                    res2_q <= rnd_res;
                end
            end

            assign res_out = res2_q;
        end else begin : g_split
            p2_t  p2_q;
            res_t res_q [3:NSTAGE];

            always_ff @(posedge clk) begin
                if (ld[2]) begin
                    p2_q.sign <= p1_q.sign;
                    p2_q.exp  <= p1_q.exp;
                    p2_q.cls  <= p1_q.cls;
                    p2_q.prod <= 48'(p1_q.m1) * 48'(p1_q.m2);
                    p2_q.tag  <= p1_q.tag;
                end
            end

            assign rnd_prod = p2_q.prod;
            assign rnd_sign = p2_q.sign;
            assign rnd_exp  = p2_q.exp;
            assign rnd_cls  = p2_q.cls;
            assign rnd_tag  = p2_q.tag;

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned k = 3; k <= NSTAGE; k++) begin
                        res_q[k] <= '0;
                    end
                end else begin
                    if (ld[3]) begin
                        res_q[3] <= rnd_res;
                    end
                    for (int unsigned k = 4; k <= NSTAGE; k++) begin
                        if (ld[k]) begin
                            res_q[k] <= res_q[k-1];
                        end
                    end
                end
            end

            assign res_out = res_q[NSTAGE];
        end
    endgenerate

    assign y       = res_out.y;
    assign ovf     = res_out.ovf;
    assign unf     = res_out.unf;
    assign out_tag = res_out.tag;

endmodule

// File: tb/tb_fmul_pipe.sv
// Self-checking bench for fmul_pipe: a real-arithmetic reference model feeds
// an in-order scoreboard checked on every delivered result, plus directed
// cases with literal expectations, backpressure, mid-flight reset and a
// randomized run with random out_ready.
module tb_fmul_pipe;

    localparam int unsigned NSTAGE = 3;
    localparam int unsigned TAG_W  = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      x1 = '0;
    logic [31:0]      x2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      y;
    logic             ovf;
    logic             unf;
    logic [TAG_W-1:0] out_tag;

    fmul_pipe #(.NSTAGE(NSTAGE), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .unf       (unf),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      y;
        logic             ovf;
        logic             unf;
        logic [TAG_W-1:0] tag;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_acc = 0;
    int   n_del = 0;
    exp_t q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: exact product in double precision, then RNE to 24 bits.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [TAG_W-1:0] t);
        exp_t   r;
        logic   s;
        int     ea, eb, e, be;
        real    p, sc, f;
        longint fi;
        logic   nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        r      = '0;
        r.tag  = t;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        nan_a  = (ea == 255) && (a[22:0] != 0);
        nan_b  = (eb == 255) && (b[22:0] != 0);
        inf_a  = (ea == 255) && (a[22:0] == 0);
        inf_b  = (eb == 255) && (b[22:0] == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            r.y = 32'h7fc00000;
            return r;
        end
        if (inf_a || inf_b) begin
            r.y = {s, 8'hff, 23'h0};
            return r;
        end
        if (zero_a || zero_b) begin
            r.y = {s, 31'h0};
            return r;
        end
        p = (1.0 + real'(int'(a[22:0])) / 8388608.0) *
            (1.0 + real'(int'(b[22:0])) / 8388608.0);
        e = ea + eb - 254;
        if (p >= 2.0) begin
            p = p / 2.0;
            e++;
        end
        sc = p * 8388608.0;
        f  = $floor(sc);
        if (((sc - f) > 0.5) || (((sc - f) == 0.5) && ($rtoi(f) % 2 == 1)))
            f = f + 1.0;
        if (f >= 16777216.0) begin
            f = f / 2.0;
            e++;
        end
        be = e + 127;
        if (be >= 255) begin
            r.y   = {s, 8'hff, 23'h0};
            r.ovf = 1'b1;
        end else if (be <= 0) begin
            r.y   = {s, 31'h0};
            r.unf = 1'b1;
        end else begin
            fi  = longint'(f);
            r.y = {s, be[7:0], fi[22:0]};
        end
        return r;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    logic             stall_prev = 1'b0;
    logic [TAG_W+33:0] held = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", 64'({out_valid, y, ovf, unf, out_tag}), 64'({1'b1, held}));
            if (in_valid && in_ready) begin
                q.push_back(model(x1, x2, in_tag));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_out: got tag %h y %h, expected no result", out_tag, y);
                end else begin
                    e = q.pop_front();
                    check("result", 64'({y, ovf, unf, out_tag}), 64'(e));
                    n_del++;
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {y, ovf, unf, out_tag};
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        logic ok;
        int   k;
        x1 = a; x2 = b; in_tag = t; in_valid = 1'b1;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            k++;
        end
        if (!ok) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic dir(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ey, input logic eo, input logic eu,
                       input logic [TAG_W-1:0] t);
        int   acc;
        logic found;
        out_ready = 1'b1;
        x1 = a; x2 = b; in_tag = t; in_valid = 1'b1;
        found = 1'b0;
        acc   = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (in_ready) begin
                found = 1'b1;
                acc   = cyc;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!found) begin
            check({nm, "_accept"}, 64'(0), 64'(1));
        end else begin
            found = 1'b0;
            for (int k = 0; k < 50 && !found; k++) begin
                @(negedge clk);
                if (out_valid) found = 1'b1;
            end
            check({nm, "_latency"}, found ? 64'(cyc - acc) : 64'(9999), 64'(NSTAGE));
            check({nm, "_value"}, 64'({y, ovf, unf, out_tag}), 64'({ey, eo, eu, t}));
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] m;
        logic        s;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        case ($urandom_range(0, 15))
            0:       e = 8'd0;
            1:       begin e = 8'hff; m = '0; end
            2:       begin e = 8'hff; m = m | 23'd1; end
            3:       e = 8'($urandom_range(190, 254));
            4:       e = 8'($urandom_range(1, 64));
            5:       begin e = 8'd127; m = 23'h7fffff - 23'($urandom_range(0, 7)); end
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {s, e, m};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        o;
        logic        u;
    } dvec_t;

    dvec_t dv [9];

    initial begin
        int   a0, d0, issued;
        logic acc;

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({out_valid, y, ovf, unf, out_tag}), 64'(0));
        rst = 1'b0;

        // pin the reference model against hand-computed values
        check("model_1p5sq",  64'(model(32'h3fc00000, 32'h3fc00000, '0).y), 64'(32'h40100000));
        check("model_rne",    64'(model(32'h3f800001, 32'h3f800001, '0).y), 64'(32'h3f800002));
        check("model_ovf",    64'({model(32'h7f000000, 32'h40000000, '0).y, model(32'h7f000000, 32'h40000000, '0).ovf}),
                              64'({32'h7f800000, 1'b1}));
        check("model_unf",    64'({model(32'h00800000, 32'h00800000, '0).y, model(32'h00800000, 32'h00800000, '0).unf}),
                              64'({32'h00000000, 1'b1}));
        check("model_infx0",  64'(model(32'h7f800000, 32'h00000000, '0).y), 64'(32'h7fc00000));

        // directed cases with literal expectations and latency
        dv[0] = '{32'h3f800000, 32'h3f800000, 32'h3f800000, 1'b0, 1'b0};
        dv[1] = '{32'hc0000000, 32'h40400000, 32'hc0c00000, 1'b0, 1'b0};
        dv[2] = '{32'h3fc00000, 32'h3fc00000, 32'h40100000, 1'b0, 1'b0};
        dv[3] = '{32'h3f800001, 32'h3f800001, 32'h3f800002, 1'b0, 1'b0};
        dv[4] = '{32'h7f000000, 32'h40000000, 32'h7f800000, 1'b1, 1'b0};
        dv[5] = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1};
        dv[6] = '{32'h00400000, 32'h3f800000, 32'h00000000, 1'b0, 1'b0};
        dv[7] = '{32'h7f800000, 32'h00000000, 32'h7fc00000, 1'b0, 1'b0};
        dv[8] = '{32'hff800000, 32'h40000000, 32'hff800000, 1'b0, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++)
            dir($sformatf("dir%0d", i), dv[i].a, dv[i].b, dv[i].y, dv[i].o, dv[i].u, TAG_W'(i + 1));

        // backpressure: 10 stalled cycles while 8 ops are offered
        out_ready = 1'b0;
        a0 = n_acc;
        d0 = n_del;
        fork
            begin
                repeat (10) @(posedge clk);
                #2;
                check("bp_accepts",  64'(n_acc - a0), 64'(NSTAGE));
                check("bp_in_ready", 64'(in_ready), 64'(0));
                out_ready = 1'b1;
            end
            begin
                for (int k = 0; k < 8; k++)
                    send(rand_fp(), rand_fp(), TAG_W'(k));
                in_valid = 1'b0;
            end
        join
        for (int k = 0; k < 100 && (n_del - d0) < 8; k++) @(posedge clk);
        #1;
        check("bp_delivered", 64'(n_del - d0), 64'(8));
        check("bp_queue_empty", 64'(q.size()), 64'(0));

        // reset with 3 ops in flight
        out_ready = 1'b0;
        send(32'h40000000, 32'h40000000, TAG_W'(20));
        send(32'h40400000, 32'h40400000, TAG_W'(21));
        send(32'h40800000, 32'h40800000, TAG_W'(22));
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_flush", 64'({out_valid, y, ovf, unf, out_tag}), 64'(0));
        out_ready = 1'b1;
        for (int k = 0; k < int'(NSTAGE) + 3; k++) begin
            @(negedge clk);
            check("post_rst_idle", 64'(out_valid), 64'(0));
        end
        @(posedge clk); #1;
        dir("post_rst_op", 32'h40a00000, 32'hc0000000, 32'hc1200000, 1'b0, 1'b0, TAG_W'(9));

        // randomized traffic with random out_ready
        issued = 0;
        acc    = 1'b0;
        for (int c = 0; c < 20000 && issued < 3000; c++) begin
            @(posedge clk); #1;
            if (acc || !in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    x1       = rand_fp();
                    x2       = rand_fp();
                    in_tag   = TAG_W'($urandom);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) issued++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
        #1;
        check("rand_issued", 64'(issued), 64'(3000));
        check("drain_empty", 64'(q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
